// File: rtl/sim_uart_frame_peer_if.sv
// UART frame peer bundle: serial pins plus the parallel TX/RX frame handshakes.
// Latency: none, wiring only.
// Backpressure: tx_vld/tx_rdy for frames to send; rx_rdy/rx_ack for frames received.
// Ports: master = environment side (drives uart_rx, tx_data, tx_vld, rx_ack, rx_err_clr);
//        slave  = peer side (drives uart_tx, tx_rdy, rx_data, rx_rdy, rx_err).
interface sim_uart_frame_peer_if #(
  parameter int TX_BYTES = 11,
  parameter int RX_BYTES = 11
);
  logic                  uart_rx;
  logic                  uart_tx;
  logic [TX_BYTES*8-1:0] tx_data;
  logic                  tx_vld;
  logic                  tx_rdy;
  logic [RX_BYTES*8-1:0] rx_data;
  logic                  rx_rdy;
  logic                  rx_ack;
  logic [3:0]            rx_err;
  logic                  rx_err_clr;

  modport master (
    output uart_rx, tx_data, tx_vld, rx_ack, rx_err_clr,
    input  uart_tx, tx_rdy, rx_data, rx_rdy, rx_err
  );

  modport slave (
    input  uart_rx, tx_data, tx_vld, rx_ack, rx_err_clr,
    output uart_tx, tx_rdy, rx_data, rx_rdy, rx_err
  );
endinterface

// File: rtl/sim_uart_frame_peer.sv
// UART frame peer: sends TX_BYTES-byte frames on uart_tx and collects RX_BYTES-byte frames from uart_rx.
// Latency: start bit begins the cycle after tx_vld is accepted; rx_rdy rises at mid-stop of the last byte.
// Backpressure: tx_vld ignored while tx_rdy=0; a received frame is held until rx_ack, and bytes arriving meanwhile flag overrun.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries uart_rx/uart_tx,
//        tx_data/tx_vld/tx_rdy, rx_data/rx_rdy/rx_ack, rx_err {timeout, overrun, framing, parity}/rx_err_clr.
module sim_uart_frame_peer #(
  parameter int CLK_FRE      = 50,
  parameter int BAUD_RATE    = 9600,
  parameter int STOP_BIT     = 0,
  parameter int CHECK_BIT    = 0,
  parameter int TX_BYTES     = 11,
  parameter int RX_BYTES     = 11,
  parameter int TIMEOUT_BITS = 20
) (
  input logic                 clk,
  input logic                 rst_n,
  sim_uart_frame_peer_if.slave bus
);
  localparam int BIT_CYC  = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int TO_CYC   = TIMEOUT_BITS * BIT_CYC;
  localparam int CW       = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int TW       = $clog2(TO_CYC + 1);
  localparam int TBW      = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
  localparam int RBW      = (RX_BYTES > 1) ? $clog2(RX_BYTES) : 1;
  localparam int RXW      = RX_BYTES * 8;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);

  // Parity bit that makes the byte odd (CHECK_BIT=1) or even (CHECK_BIT=2).
  function automatic logic parityOf(input logic [7:0] b);
    return (CHECK_BIT == 1) ? ~^b : ^b;
  endfunction

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
  txState_t              txState;
  logic [CW-1:0]         txCnt;
  logic [2:0]            txBitIdx;
  logic                  txStopIdx;
  logic [TBW-1:0]        txByteIdx;
  logic [TX_BYTES*8-1:0] txFrame;
  logic [TX_BYTES*8-1:0] txFrameNext;
  logic [7:0]            txCur;
  logic                  txPar;
  logic                  txLine;
  logic                  txRdy;

  // Remaining bytes shift down so the next one to send is always at [7:0].
  assign txFrameNext = txFrame >> 8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState   <= TX_IDLE;
      txCnt     <= '0;
      txBitIdx  <= '0;
      txStopIdx <= 1'b0;
      txByteIdx <= '0;
      txFrame   <= '0;
      txCur     <= '0;
      txPar     <= 1'b0;
      txLine    <= 1'b1;
      txRdy     <= 1'b1;
    end else if (txState == TX_IDLE) begin
      if (bus.tx_vld) begin
        txFrame   <= bus.tx_data;
        txCur     <= bus.tx_data[7:0];
        txPar     <= parityOf(bus.tx_data[7:0]);
        txByteIdx <= '0;
        txCnt     <= '0;
        txRdy     <= 1'b0;
        txLine    <= 1'b0;
        txState   <= TX_START;
      end
    end else if (txCnt != BIT_LAST) begin
      txCnt <= txCnt + 1'b1;
    end else begin
      // Bit boundary: the next line level is registered here so it appears exactly on the boundary.
      txCnt <= '0;
      case (txState)
        TX_START: begin
          txLine   <= txCur[0];
          txBitIdx <= '0;
          txState  <= TX_DATA;
        end
        TX_DATA: begin
          if (txBitIdx == 3'd7) begin
            if (CHECK_BIT != 0) begin
              txLine  <= txPar;
              txState <= TX_PARITY;
            end else begin
              txLine    <= 1'b1;
              txStopIdx <= 1'b0;
              txState   <= TX_STOP;
            end
          end else begin
            txBitIdx <= txBitIdx + 3'd1;
            txCur    <= txCur >> 1;
            txLine   <= txCur[1];
          end
        end
        TX_PARITY: begin
          txLine    <= 1'b1;
          txStopIdx <= 1'b0;
          txState   <= TX_STOP;
        end
        TX_STOP: begin
          if (STOP_BIT != 0 && !txStopIdx) begin
            txStopIdx <= 1'b1;
          end else if (txByteIdx == TBW'(TX_BYTES - 1)) begin
            txState <= TX_IDLE;
            txRdy   <= 1'b1;
          end else begin
            txByteIdx <= txByteIdx + 1'b1;
            txFrame   <= txFrameNext;
            txCur     <= txFrameNext[7:0];
            txPar     <= parityOf(txFrameNext[7:0]);
            txLine    <= 1'b0;
            txState   <= TX_START;
          end
        end
        default: txState <= TX_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rxState_t;
  rxState_t       rxState;
  logic           rxS1, rxS2, rxPrev;
  logic           fallEdge;
  logic           rxBitEnd;
  logic [CW-1:0]  rxCnt;
  logic [2:0]     rxBitIdx;
  logic [7:0]     rxShift;
  logic [RBW-1:0] rxByteCnt;
  logic [TW-1:0]  toCnt;
  logic [RXW-1:0] rxBuf;
  logic [RXW-1:0] rxBufNext;
  logic [RXW-1:0] rxData;
  logic           rxRdy;
  logic [3:0]     rxErr;
  logic           parErr, frmErr, ovrErr, toErr;

  // New bytes enter at the top, so after RX_BYTES bytes the first one sits at [7:0].
  assign rxBufNext = RXW'({rxShift, rxBuf} >> 8);

  always_comb begin
    fallEdge = rxPrev & ~rxS2;
    rxBitEnd = (rxCnt == BIT_LAST);
    parErr   = (rxState == RX_PARITY) && rxBitEnd && (rxS2 != parityOf(rxShift));
    frmErr   = (rxState == RX_STOP) && rxBitEnd && !rxS2;
    ovrErr   = (rxState == RX_WAIT) && fallEdge;
    toErr    = (rxState == RX_IDLE) && (rxByteCnt != '0) && !fallEdge && (toCnt == TW'(TO_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxS1      <= 1'b1;
      rxS2      <= 1'b1;
      rxPrev    <= 1'b1;
      rxState   <= RX_IDLE;
      rxCnt     <= '0;
      rxBitIdx  <= '0;
      rxShift   <= '0;
      rxByteCnt <= '0;
      toCnt     <= '0;
      rxBuf     <= '0;
      rxData    <= '0;
      rxRdy     <= 1'b0;
      rxErr     <= '0;
    end else begin
      rxS1   <= bus.uart_rx;
      rxS2   <= rxS1;
      rxPrev <= rxS2;
      // A fresh error in the clearing cycle survives the clear.
      rxErr  <= (bus.rx_err_clr ? 4'b0000 : rxErr) | {toErr, ovrErr, frmErr, parErr};
      case (rxState)
        RX_IDLE: begin
          if (fallEdge) begin
            rxCnt   <= '0;
            toCnt   <= '0;
            rxState <= RX_START;
          end else if (toErr) begin
            rxByteCnt <= '0;
            toCnt     <= '0;
          end else if (rxByteCnt != '0) begin
            toCnt <= toCnt + 1'b1;
          end
        end
        RX_START: begin
          // Half a bit after the edge: a high line means it was only a glitch.
          if (rxCnt == CW'(HALF_CYC)) begin
            rxCnt <= '0;
            if (rxS2) begin
              rxState <= RX_IDLE;
            end else begin
              rxBitIdx <= '0;
              rxState  <= RX_DATA;
            end
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rxBitEnd) begin
            rxCnt   <= '0;
            rxShift <= {rxS2, rxShift[7:1]};
            if (rxBitIdx == 3'd7) rxState <= (CHECK_BIT != 0) ? RX_PARITY : RX_STOP;
            else                  rxBitIdx <= rxBitIdx + 3'd1;
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rxBitEnd) begin
            rxCnt   <= '0;
            rxState <= RX_STOP;
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rxBitEnd) begin
            rxCnt <= '0;
            toCnt <= '0;
            if (rxByteCnt == RBW'(RX_BYTES - 1)) begin
              rxData    <= rxBufNext;
              rxRdy     <= 1'b1;
              rxByteCnt <= '0;
              rxState   <= RX_WAIT;
            end else begin
              rxBuf     <= rxBufNext;
              rxByteCnt <= rxByteCnt + 1'b1;
              rxState   <= RX_IDLE;
            end
          end else begin
            rxCnt <= rxCnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (bus.rx_ack) begin
            rxRdy   <= 1'b0;
            rxState <= RX_IDLE;
          end
        end
        default: rxState <= RX_IDLE;
      endcase
    end
  end

  assign bus.uart_tx = txLine;
  assign bus.tx_rdy  = txRdy;
  assign bus.rx_data = rxData;
  assign bus.rx_rdy  = rxRdy;
  assign bus.rx_err  = rxErr;
endmodule

// File: tb/tb_sim_uart_frame_peer.sv
// Directed bench for sim_uart_frame_peer: 16-clock bits, even parity, two stop bits, 11-byte frames.
// Latency: checks sampled on the falling clock edge, away from the active edge.
// Backpressure: exercises tx busy, rx hold-until-ack and overrun.
module tb_sim_uart_frame_peer;
  localparam int BIT = 16;
  localparam int NB  = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic loopSel = 1'b0;
  logic tbRx = 1'b1;
  int   passCnt = 0;
  int   failCnt = 0;
  int   totalCnt = 0;

  sim_uart_frame_peer_if #(.TX_BYTES(NB), .RX_BYTES(NB)) bus();
  assign bus.uart_rx = loopSel ? bus.uart_tx : tbRx;

  sim_uart_frame_peer #(
    .CLK_FRE(50), .BAUD_RATE(3125000), .STOP_BIT(1), .CHECK_BIT(2),
    .TX_BYTES(NB), .RX_BYTES(NB), .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sendBit(input logic b);
    tbRx = b;
    repeat (BIT) @(negedge clk);
  endtask

  // Start, 8 data LSB first, even parity (optionally inverted), stop (optionally 0), second stop.
  task automatic sendByte(input logic [7:0] b, input logic badPar, input logic badStop);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
    sendBit(^b ^ badPar);
    sendBit(!badStop);
    sendBit(1'b1);
  endtask

  task automatic waitRxRdy(input int limit);
    for (int i = 0; i < limit && bus.rx_rdy !== 1'b1; i++) @(negedge clk);
  endtask

  initial begin
    logic [NB*8-1:0] frame1, frame2, frame3, frame5;
    logic [0:23]     exp1;
    int              lowCnt;
    int              bitIdx;

    bus.tx_data = '0;
    bus.tx_vld = 1'b0;
    bus.rx_ack = 1'b0;
    bus.rx_err_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("reset uart_tx", bus.uart_tx, 1'b1);
    check("reset tx_rdy", bus.tx_rdy, 1'b1);
    check("reset rx_rdy", bus.rx_rdy, 1'b0);
    check("reset rx_data", bus.rx_data, '0);
    check("reset rx_err", bus.rx_err, 4'b0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // TX waveform: 0x55 then 0xA5 with even parity and two stop bits
    frame1 = '0;
    frame1[7:0] = 8'h55;
    frame1[15:8] = 8'hA5;
    exp1 = 24'b0_10101010_0_11_0_10100101_0_11;
    bus.tx_data = frame1;
    bus.tx_vld = 1'b1;
    @(negedge clk);
    bus.tx_vld = 1'b0;
    lowCnt = 0;
    bitIdx = 0;
    for (int n = 0; n < 3000 && bus.tx_rdy === 1'b0; n++) begin
      if (bitIdx < 24 && n == 8 + BIT * bitIdx) begin
        check($sformatf("tx bit %0d", bitIdx), bus.uart_tx, exp1[bitIdx]);
        bitIdx++;
      end
      if (n == 100) bus.tx_vld = 1'b1;
      if (n == 101) bus.tx_vld = 1'b0;
      lowCnt++;
      @(negedge clk);
    end
    check("tx bits sampled", bitIdx, 24);
    check("tx_rdy low cycles", lowCnt, 2112);
    check("tx_rdy back high", bus.tx_rdy, 1'b1);

    // Full-duplex loopback of bytes 0x00..0x0A
    loopSel = 1'b1;
    for (int k = 0; k < NB; k++) frame2[8*k +: 8] = 8'(k);
    bus.tx_data = frame2;
    bus.tx_vld = 1'b1;
    @(negedge clk);
    bus.tx_vld = 1'b0;
    waitRxRdy(4000);
    check("loop rx_rdy", bus.rx_rdy, 1'b1);
    check("loop rx_data", bus.rx_data, frame2);
    check("loop rx_err", bus.rx_err, 4'b0000);
    for (int i = 0; i < 4000 && bus.tx_rdy !== 1'b1; i++) @(negedge clk);
    check("loop tx done", bus.tx_rdy, 1'b1);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    check("loop ack drops rx_rdy", bus.rx_rdy, 1'b0);
    loopSel = 1'b0;
    repeat (5) @(negedge clk);

    // Parity error on byte 0, framing error on byte 1; frame still completes
    for (int k = 0; k < NB; k++) begin
      frame3[8*k +: 8] = (k == 0) ? 8'h07 : 8'(8'h30 + k);
      sendByte(frame3[8*k +: 8], k == 0, k == 1);
    end
    check("err frame rx_rdy", bus.rx_rdy, 1'b1);
    check("err frame rx_data", bus.rx_data, frame3);
    check("err frame rx_err", bus.rx_err, 4'b0011);
    bus.rx_err_clr = 1'b1;
    @(negedge clk);
    bus.rx_err_clr = 1'b0;
    check("err clear", bus.rx_err, 4'b0000);

    // Overrun: one more byte while the frame is still unacknowledged
    sendByte(8'h5A, 1'b0, 1'b0);
    check("overrun rx_err", bus.rx_err, 4'b0100);
    check("overrun rx_rdy held", bus.rx_rdy, 1'b1);
    check("overrun rx_data held", bus.rx_data, frame3);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    check("overrun ack", bus.rx_rdy, 1'b0);
    bus.rx_err_clr = 1'b1;
    @(negedge clk);
    bus.rx_err_clr = 1'b0;
    check("overrun clear", bus.rx_err, 4'b0000);

    // Inter-byte timeout after 3 of 11 bytes, then a clean frame
    sendByte(8'h11, 1'b0, 1'b0);
    sendByte(8'h22, 1'b0, 1'b0);
    sendByte(8'h33, 1'b0, 1'b0);
    repeat (21 * BIT) @(negedge clk);
    check("timeout rx_err", bus.rx_err, 4'b1000);
    check("timeout no rx_rdy", bus.rx_rdy, 1'b0);
    bus.rx_err_clr = 1'b1;
    @(negedge clk);
    bus.rx_err_clr = 1'b0;
    check("timeout clear", bus.rx_err, 4'b0000);
    for (int k = 0; k < NB; k++) begin
      frame5[8*k +: 8] = 8'(8'hC0 + k);
      sendByte(frame5[8*k +: 8], 1'b0, 1'b0);
    end
    check("after timeout rx_rdy", bus.rx_rdy, 1'b1);
    check("after timeout rx_data", bus.rx_data, frame5);
    check("after timeout rx_err", bus.rx_err, 4'b0000);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    check("after timeout ack", bus.rx_rdy, 1'b0);

    // Short low glitch: no byte, so no later timeout and no error
    tbRx = 1'b0;
    repeat (4) @(negedge clk);
    tbRx = 1'b1;
    repeat (25 * BIT) @(negedge clk);
    check("glitch rx_err", bus.rx_err, 4'b0000);
    check("glitch rx_rdy", bus.rx_rdy, 1'b0);

    // Reset in the middle of a transmitted all-zero byte
    bus.tx_data = '0;
    bus.tx_vld = 1'b1;
    @(negedge clk);
    bus.tx_vld = 1'b0;
    repeat (50) @(negedge clk);
    check("mid-tx line low", bus.uart_tx, 1'b0);
    check("mid-tx busy", bus.tx_rdy, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset mid-tx uart_tx", bus.uart_tx, 1'b1);
    check("reset mid-tx tx_rdy", bus.tx_rdy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post reset uart_tx idle", bus.uart_tx, 1'b1);
    check("post reset rx_data", bus.rx_data, '0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
